// File: rtl/pulse_arb_pkg.sv
// Shared types and defaults for the pulse event arbiter.
package pulse_arb_pkg;

  localparam int unsigned N_CH_DEF  = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pulse_sync_edge.sv
// One-channel 2-flop synchronizer followed by a registered rising-edge detector.
// Ports: clk, rst (async active-low), noisy (async level), pulse (1-cycle edge).
module pulse_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // prev resets to 0 so a level held high through reset yields one pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      sync1 <= noisy;
      sync2 <= sync1;
      prev  <= sync2;
      pulse <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/pulse_event_arbiter.sv
// Collects edge events from N_CH asynchronous pulse inputs and offers them one
// record per cycle, round-robin, over a valid/ready handshake. Events arriving
// on a channel that is already pending are counted as drops.
// Ports: clk, rst (async active-low); noisy_in/ch_en per channel;
//        evt_valid/evt_ready/evt_ch record handshake;
//        drop_cnt (saturating), ovf_sticky (per channel), clr_ovf clear strobe.
module pulse_event_arbiter
  import pulse_arb_pkg::*;
#(
  parameter int unsigned N_CH  = N_CH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         noisy_in,
  input  logic [N_CH-1:0]         ch_en,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic [CNT_W-1:0]        drop_cnt,
  output logic [N_CH-1:0]         ovf_sticky,
  input  logic                    clr_ovf
);

  localparam int unsigned CH_W  = $clog2(N_CH);
  localparam int unsigned SUM_W = CNT_W + 5;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0] edge_pls;

  arb_state_e      state, state_nxt;
  logic [CH_W-1:0] evt_ch_nxt;
  logic [CH_W-1:0] last_grant, last_nxt;
  logic [N_CH-1:0] pending, pending_nxt;
  logic [N_CH-1:0] grant;
  logic [N_CH-1:0] drop_vec;
  logic [N_CH-1:0] ovf_nxt;
  logic [CNT_W-1:0] drop_nxt;
  logic [CNT_W-1:0] drop_base;
  logic [4:0]       ndrop;
  logic [SUM_W-1:0] drop_sum;
  logic [CH_W-1:0]  idx;
  logic [CH_W-1:0]  win;
  logic             found;

  genvar g;
  generate
    for (g = 0; g < N_CH; g++) begin : g_ch
      pulse_sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .noisy (noisy_in[g]),
        .pulse (edge_pls[g])
      );
    end
  endgenerate

  assign evt_valid = (state == OFFER);

  // State and bookkeeping registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      evt_ch     <= '0;
      last_grant <= LAST_CH;
      pending    <= '0;
      drop_cnt   <= '0;
      ovf_sticky <= '0;
    end else begin
      state      <= state_nxt;
      evt_ch     <= evt_ch_nxt;
      last_grant <= last_nxt;
      pending    <= pending_nxt;
      drop_cnt   <= drop_nxt;
      ovf_sticky <= ovf_nxt;
    end
  end

  // Round-robin selection, FSM next state, pending and drop accounting
  always_comb begin
    state_nxt  = state;
    evt_ch_nxt = evt_ch;
    last_nxt   = last_grant;
    grant      = '0;
    found      = 1'b0;
    win        = '0;
    idx        = '0;
    ndrop      = '0;

    // Scan from last_grant+1, wrapping at N_CH-1
    for (int unsigned i = 1; i <= N_CH; i++) begin
      idx = CH_W'((32'(last_grant) + i) % N_CH);
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_nxt  = OFFER;
          evt_ch_nxt = win;
          last_nxt   = win;
          grant[win] = 1'b1;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          if (found) begin
            evt_ch_nxt = win;
            last_nxt   = win;
            grant[win] = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A new edge on a channel being granted this cycle re-arms it without a drop
    drop_vec    = edge_pls & ch_en & pending & ~grant;
    pending_nxt = (pending & ~grant) | (edge_pls & ch_en);

    for (int unsigned i = 0; i < N_CH; i++) begin
      ndrop = ndrop + 5'(drop_vec[i]);
    end

    // Clear first, then add this cycle's drops so a coincident drop survives
    drop_base = clr_ovf ? '0 : drop_cnt;
    drop_sum  = SUM_W'(drop_base) + SUM_W'(ndrop);
    if (drop_sum > SUM_W'(CNT_MAX)) begin
      drop_nxt = CNT_MAX;
    end else begin
      drop_nxt = CNT_W'(drop_sum);
    end
    ovf_nxt = (clr_ovf ? '0 : ovf_sticky) | drop_vec;
  end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench with an expected-record queue checked by a handshake monitor.
module tb_pulse_event_arbiter;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  noisy_in;
  logic [N_CH-1:0]  ch_en;
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_ch;
  logic [CNT_W-1:0] drop_cnt;
  logic [N_CH-1:0]  ovf_sticky;
  logic             clr_ovf;

  int checks = 0;
  int errors = 0;
  int rec_count = 0;
  int exp_q[$];

  pulse_event_arbiter #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .noisy_in   (noisy_in),
    .ch_en      (ch_en),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ch     (evt_ch),
    .drop_cnt   (drop_cnt),
    .ovf_sticky (ovf_sticky),
    .clr_ovf    (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted record must match the head of the expected queue
  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      int e;
      rec_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL record_unexpected: got ch %0d, required none", evt_ch);
      end else begin
        e = exp_q.pop_front();
        if (int'(evt_ch) != e) begin
          errors++;
          $display("FAIL record_ch: got ch %0d, required ch %0d", evt_ch, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input logic [N_CH-1:0] m);
    noisy_in = m;
    repeat (3) tick();
    noisy_in = '0;
    repeat (4) tick();
  endtask

  task automatic clear_ovf();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || evt_valid) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || evt_valid) begin
      errors++;
      $display("FAIL %s_drain: %0d records outstanding, required 0", name, exp_q.size());
    end
  endtask

  initial begin
    int first;
    int nvalid;
    int rc;

    rst       = 1'b0;
    noisy_in  = '0;
    ch_en     = '1;
    evt_ready = 1'b1;
    clr_ovf   = 1'b0;
    repeat (3) tick();

    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_evt_ch", int'(evt_ch), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    chk("rst_ovf_sticky", int'(ovf_sticky), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Four simultaneous edges after reset: ch0..ch3 on consecutive cycles
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    noisy_in = 4'b1111;
    first = 0;
    while (!evt_valid && first < 10) begin
      tick();
      first++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("burst_valid", int'(evt_valid), 1);
      chk("burst_ch", int'(evt_ch), i);
      tick();
    end
    chk("burst_end_valid", int'(evt_valid), 0);
    noisy_in = '0;
    wait_idle("burst");
    repeat (4) tick();

    // Single ch2 pulse: valid exactly one cycle, 4 cycles after sampling edge
    exp_q.push_back(2);
    noisy_in = 4'b0100;
    tick();
    first = -1;
    nvalid = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) noisy_in = '0;
      if (evt_valid && first < 0) first = c;
      if (evt_valid) nvalid++;
    end
    chk("single_latency", first, 4);
    chk("single_width", nvalid, 1);
    chk("single_drop_cnt", int'(drop_cnt), 0);
    wait_idle("single");

    // Stalled ch1 record while ch3 pulses twice: one pending, one drop
    evt_ready = 1'b0;
    exp_q.push_back(1);
    pulse(4'b0010);
    exp_q.push_back(3);
    pulse(4'b1000);
    pulse(4'b1000);
    chk("stall_valid", int'(evt_valid), 1);
    chk("stall_ch", int'(evt_ch), 1);
    chk("stall_drop_cnt", int'(drop_cnt), 1);
    chk("stall_ovf", int'(ovf_sticky), 8);
    evt_ready = 1'b1;
    wait_idle("stall");
    clear_ovf();
    chk("clr_drop_cnt", int'(drop_cnt), 0);
    chk("clr_ovf_sticky", int'(ovf_sticky), 0);

    // Channel 2 disabled: its edge vanishes without counting a drop
    ch_en = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    pulse(4'b1111);
    wait_idle("chen");
    chk("chen_drop_cnt", int'(drop_cnt), 0);
    ch_en = '1;

    // Saturation: hold ch1 offered, pend ch0, then 256 further ch0 edges
    evt_ready = 1'b0;
    exp_q.push_back(1);
    pulse(4'b0010);
    exp_q.push_back(0);
    pulse(4'b0001);
    for (int i = 0; i < 255; i++) pulse(4'b0001);
    chk("sat_255", int'(drop_cnt), 255);
    pulse(4'b0001);
    chk("sat_hold", int'(drop_cnt), 255);
    chk("sat_ovf", int'(ovf_sticky), 1);

    // Drop landing in the clear cycle wins over the clear
    noisy_in = 4'b0001;
    repeat (3) tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    noisy_in = '0;
    chk("clr_race_cnt", int'(drop_cnt), 1);
    chk("clr_race_ovf", int'(ovf_sticky), 1);
    repeat (4) tick();
    clear_ovf();
    chk("sat_clr_cnt", int'(drop_cnt), 0);
    chk("sat_clr_ovf", int'(ovf_sticky), 0);
    evt_ready = 1'b1;
    wait_idle("sat");

    // Reset during OFFER with three pending: everything discarded
    evt_ready = 1'b0;
    pulse(4'b0010);
    pulse(4'b1101);
    chk("pre_rst_valid", int'(evt_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(evt_valid), 0);
    chk("mid_rst_ch", int'(evt_ch), 0);
    repeat (2) tick();
    rst = 1'b1;
    evt_ready = 1'b1;
    rc = rec_count;
    repeat (20) tick();
    chk("post_rst_records", rec_count - rc, 0);

    // First grant after reset scans from channel 0
    exp_q.push_back(0); exp_q.push_back(2);
    pulse(4'b0101);
    wait_idle("post_rst");

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
